// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a DEPTH x 32-bit register memory; no RRESP, full-word writes only.
// Optional privilege check enabled by defining AXI_LITE_SLAVE_PROT_CHECK_EN.
`timescale 1ns/1ps
module axi_lite_slave_mem #(
    parameter int unsigned DEPTH       = 16,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [3:0]  AWCACHE,
    input  logic [2:0]  AWPROT,
    input  logic [31:0] WDATA,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    input  logic [3:0]  ARCACHE,
    input  logic [2:0]  ARPROT,
    output logic [31:0] RDATA,
    output logic        RVALID,
    input  logic        RREADY
);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e       w_state_q, w_state_d;
    r_state_e       r_state_q, r_state_d;
    logic [IW-1:0]  waddr_idx_q, waddr_idx_d;
    logic           waddr_ok_q, waddr_ok_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [1:0]     bresp_q, bresp_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           ready_en_q, ready_en_d;
    logic [31:0]    mem_q [DEPTH];
    logic [31:0]    mem_d [DEPTH];

    logic           aw_hs, w_hs, ar_hs;
    logic [IW-1:0]  aw_idx, ar_idx, c_idx;
    logic           aw_ok, ar_ok, c_ok, commit;
    logic [31:0]    c_data;
    logic           unused_inputs;

`ifdef AXI_LITE_SLAVE_PROT_CHECK_EN
    assign aw_ok = (AWADDR[31:IW+2] == '0) && AWPROT[0];
    assign ar_ok = (ARADDR[31:IW+2] == '0) && ARPROT[0];
    assign unused_inputs = ^{AWADDR[1:0], ARADDR[1:0], AWCACHE, ARCACHE, AWPROT[2:1], ARPROT[2:1]};
`else
    assign aw_ok = (AWADDR[31:IW+2] == '0);
    assign ar_ok = (ARADDR[31:IW+2] == '0);
    assign unused_inputs = ^{AWADDR[1:0], ARADDR[1:0], AWCACHE, ARCACHE, AWPROT, ARPROT};
`endif

    assign aw_idx = AWADDR[IW+1:2];
    assign ar_idx = ARADDR[IW+1:2];

    // ready_en_q keeps every ready low through reset and raises them on the first edge after release
    assign AWREADY = ready_en_q && (w_state_q == W_IDLE || w_state_q == W_HAVE_DATA);
    assign WREADY  = ready_en_q && (w_state_q == W_IDLE || w_state_q == W_HAVE_ADDR);
    assign ARREADY = ready_en_q && (r_state_q == R_IDLE);
    assign BVALID  = (w_state_q == W_RESP);
    assign RVALID  = (r_state_q == R_DATA);
    assign BRESP   = bresp_q;
    assign RDATA   = rdata_q;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    always_comb begin
        ready_en_d  = 1'b1;
        w_state_d   = w_state_q;
        waddr_idx_d = waddr_idx_q;
        waddr_ok_d  = waddr_ok_q;
        wdata_d     = wdata_q;
        bresp_d     = bresp_q;
        mem_d       = mem_q;
        commit      = 1'b0;
        c_idx       = waddr_idx_q;
        c_ok        = waddr_ok_q;
        c_data      = wdata_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    c_idx  = aw_idx;
                    c_ok   = aw_ok;
                    c_data = WDATA;
                end else if (aw_hs) begin
                    waddr_idx_d = aw_idx;
                    waddr_ok_d  = aw_ok;
                    w_state_d   = W_HAVE_ADDR;
                end else if (w_hs) begin
                    wdata_d   = WDATA;
                    w_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    commit = 1'b1;
                    c_data = WDATA;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    commit = 1'b1;
                    c_idx  = aw_idx;
                    c_ok   = aw_ok;
                end
            end
            W_RESP: begin
                if (BREADY) w_state_d = W_IDLE;
            end
        endcase
        if (commit) begin
            w_state_d = W_RESP;
            bresp_d   = c_ok ? 2'b00 : 2'b10;
            if (c_ok) mem_d[c_idx] = c_data;
        end
    end

    // Read samples mem_q, so a same-edge write commit is not visible to it
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d   = ar_ok ? mem_q[ar_idx] : '0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) r_state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ready_en_q  <= 1'b0;
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            waddr_idx_q <= '0;
            waddr_ok_q  <= 1'b0;
            wdata_q     <= '0;
            bresp_q     <= 2'b00;
            rdata_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VALUE;
        end else begin
            ready_en_q  <= ready_en_d;
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            waddr_idx_q <= waddr_idx_d;
            waddr_ok_q  <= waddr_ok_d;
            wdata_q     <= wdata_d;
            bresp_q     <= bresp_d;
            rdata_q     <= rdata_d;
            mem_q       <= mem_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Randomized self-checking bench for axi_lite_slave_mem against an array-based memory model.
`timescale 1ns/1ps
module tb_axi_lite_slave_mem;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] RST_VAL = 32'hC0DE_0001;

    logic        ACLK, ARESET;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [3:0]  AWCACHE, ARCACHE;
    logic [2:0]  AWPROT, ARPROT;
    logic [1:0]  BRESP;

    axi_lite_slave_mem #(.DEPTH(DEPTH), .RESET_VALUE(RST_VAL)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
    );

    logic [31:0] model [DEPTH];
    int n_checks = 0;
    int n_errors = 0;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit access_ok(input logic [31:0] addr, input logic [2:0] prot);
        bit ok;
        ok = (addr < DEPTH * 4);
`ifdef AXI_LITE_SLAVE_PROT_CHECK_EN
        ok = ok && prot[0];
`endif
        return ok;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = RST_VAL;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] prot,
                            input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w, ok;
        int c = 0;
        logic [1:0] exp_resp;
        AWADDR = addr; AWPROT = prot; AWCACHE = 4'($urandom); WDATA = data;
        while (!(aw_done && w_done)) begin
            if (c > 40) begin
                check("wr_handshake_timeout", 32'(c), 32'd0);
                AWVALID = 0; WVALID = 0;
                return;
            end
            AWVALID = !aw_done && (c >= aw_dly);
            WVALID  = !w_done && (c >= w_dly);
            if (w_done && !aw_done) check("wready_low_have_data", 32'(WREADY), 32'd0);
            if (aw_done && !w_done) check("awready_low_have_addr", 32'(AWREADY), 32'd0);
            hs_aw = AWVALID && AWREADY;
            hs_w  = WVALID && WREADY;
            tick();
            aw_done |= hs_aw;
            w_done  |= hs_w;
            c++;
        end
        AWVALID = 0; WVALID = 0;
        ok = access_ok(addr, prot);
        exp_resp = ok ? 2'b00 : 2'b10;
        if (ok) model[addr[5:2]] = data;
        check("bvalid_after_commit", 32'(BVALID), 32'd1);
        check("bresp", 32'(BRESP), 32'(exp_resp));
        BREADY = 0;
        for (int i = 0; i < b_dly; i++) begin
            tick();
            check("bvalid_held", 32'(BVALID), 32'd1);
            check("bresp_held", 32'(BRESP), 32'(exp_resp));
            check("aw_w_ready_low_resp", {30'd0, AWREADY, WREADY}, 32'd0);
        end
        BREADY = 1;
        tick();
        BREADY = 0;
        check("bvalid_clear", 32'(BVALID), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] prot, input int r_dly);
        logic [31:0] exp;
        bit hs = 0;
        int c = 0;
        ARADDR = addr; ARPROT = prot; ARCACHE = 4'($urandom);
        ARVALID = 1;
        while (!hs) begin
            if (c > 40) begin
                check("rd_handshake_timeout", 32'(c), 32'd0);
                ARVALID = 0;
                return;
            end
            hs = ARREADY;
            tick();
            c++;
        end
        ARVALID = 0;
        exp = access_ok(addr, prot) ? model[addr[5:2]] : 32'd0;
        check("rvalid", 32'(RVALID), 32'd1);
        check("rdata", RDATA, exp);
        RREADY = 0;
        for (int i = 0; i < r_dly; i++) begin
            tick();
            check("rvalid_held", 32'(RVALID), 32'd1);
            check("rdata_held", RDATA, exp);
            check("arready_low_rdata", 32'(ARREADY), 32'd0);
        end
        RREADY = 1;
        tick();
        RREADY = 0;
        check("rvalid_clear", 32'(RVALID), 32'd0);
    endtask

    task automatic scan_all();
        for (int i = 0; i < DEPTH; i++) do_read(32'(i * 4), 3'b001, 0);
    endtask

    initial begin
        logic [31:0] addr, old;
        int mode, dly;
        ARESET = 1;
        AWADDR = 0; AWVALID = 0; AWCACHE = 0; AWPROT = 0;
        WDATA = 0; WVALID = 0; BREADY = 0;
        ARADDR = 0; ARVALID = 0; ARCACHE = 0; ARPROT = 0; RREADY = 0;
        model_reset();
        #2;
        check("rst_readies", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
        check("rst_valids", {30'd0, BVALID, RVALID}, 32'd0);
        check("rst_bresp", 32'(BRESP), 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        tick();
        tick();
        ARESET = 0;
        check("readies_before_edge", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
        tick();
        check("readies_after_release", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);
        scan_all();

        // same-cycle AW/W, then read back
        do_write(32'h04, 32'hA5A5_A5A5, 3'b001, 0, 0, 0);
        do_read(32'h04, 3'b001, 0);
        // W three cycles ahead of AW
        do_write(32'h08, 32'h1234_5678, 3'b001, 3, 0, 0);
        do_read(32'h08, 3'b001, 0);
        // out-of-range write and read
        do_write(32'h0000_0100, 32'hFFFF_FFFF, 3'b001, 0, 0, 0);
        do_read(32'h0000_0100, 3'b001, 0);
        scan_all();
        // long backpressure on B and R
        do_write(32'h10, 32'h0BAD_F00D, 3'b001, 1, 0, 10);
        do_read(32'h10, 3'b001, 10);

        // read handshake coinciding with write commit to the same word returns old data
        old = model[5];
        AWADDR = 32'h14; AWPROT = 3'b001; AWVALID = 1;
        tick();
        AWVALID = 0;
        check("have_addr_wready", {30'd0, AWREADY, WREADY}, 32'd1);
        WDATA = 32'h5555_AAAA; WVALID = 1;
        ARADDR = 32'h14; ARPROT = 3'b001; ARVALID = 1;
        check("concurrent_ready", {30'd0, WREADY, ARREADY}, 32'd3);
        tick();
        WVALID = 0; ARVALID = 0;
        model[5] = 32'h5555_AAAA;
        check("concurrent_bvalid_rvalid", {30'd0, BVALID, RVALID}, 32'd3);
        check("concurrent_old_data", RDATA, old);
        BREADY = 1; RREADY = 1;
        tick();
        BREADY = 0; RREADY = 0;
        do_read(32'h14, 3'b001, 0);

`ifdef AXI_LITE_SLAVE_PROT_CHECK_EN
        do_write(32'h00, 32'h7777_0000, 3'b000, 0, 0, 0);
        do_read(32'h00, 3'b001, 0);
        do_write(32'h00, 32'h7777_0001, 3'b001, 0, 0, 0);
        do_read(32'h00, 3'b001, 0);
        do_read(32'h00, 3'b000, 0);
`endif

        for (int n = 0; n < 80; n++) begin
            addr = 32'($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) addr = addr | (32'h1 << $urandom_range(6, 31));
            dly = $urandom_range(0, 3);
            mode = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 0)
                do_write(addr, $urandom, 3'($urandom),
                         (mode == 1) ? dly : 0, (mode == 2) ? dly : 0, $urandom_range(0, 2));
            else
                do_read(addr, 3'($urandom), $urandom_range(0, 2));
        end
        scan_all();

        // reset while holding a latched address for word 3
        do_write(32'h0C, 32'h3333_3333, 3'b001, 0, 0, 0);
        AWADDR = 32'h0C; AWPROT = 3'b001; AWVALID = 1;
        tick();
        AWVALID = 0;
        check("pre_reset_have_addr", {30'd0, AWREADY, WREADY}, 32'd1);
        #2;
        ARESET = 1;
        #1;
        check("async_rst_readies", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
        check("async_rst_valids", {30'd0, BVALID, RVALID}, 32'd0);
        model_reset();
        tick();
        ARESET = 0;
        tick();
        check("readies_after_rerelease", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);
        WDATA = 32'h9999_9999; WVALID = 1;
        tick();
        WVALID = 0;
        check("no_stale_commit", 32'(BVALID), 32'd0);
        ARESET = 1;
        #1;
        ARESET = 0;
        tick();
        do_read(32'h0C, 3'b001, 0);
        scan_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_slave_mem.md
AXI_LITE_SLAVE_MEM -- requirements
Module: axi_lite_slave_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 32-bit words (power of two, 2..256).
REQ-002 SHALL have parameter RESET_VALUE, default 32'h0000_0000, value loaded into every word at reset.
REQ-003 SHALL have port ACLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port ARESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports AWADDR in 32, AWVALID in 1, AWREADY out 1, AWCACHE in 4, AWPROT in 3: write address channel.
REQ-006 SHALL have ports WDATA in 32, WVALID in 1, WREADY out 1: write data channel, full-word writes only.
REQ-007 SHALL have ports BRESP out 2, BVALID out 1, BREADY in 1: write response channel.
REQ-008 SHALL have ports ARADDR in 32, ARVALID in 1, ARREADY out 1, ARCACHE in 4, ARPROT in 3: read address channel.
REQ-009 SHALL have ports RDATA out 32, RVALID out 1, RREADY in 1: read data channel; there is no RRESP.
REQ-010 SHALL ignore AWCACHE and ARCACHE functionally.

Function
REQ-011 SHALL decode word index = ADDR[log2(DEPTH)+1:2], ignore ADDR[1:0], and treat an address as in range iff every bit above the index field is 0.
REQ-012 SHALL implement write FSM states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
REQ-013 SHALL assert AWREADY in W_IDLE and W_HAVE_DATA only, and WREADY in W_IDLE and W_HAVE_ADDR only.
REQ-014 W_IDLE: AW and W handshakes in the same cycle SHALL commit the write that edge and go to W_RESP; AW only SHALL latch address and go to W_HAVE_ADDR; W only SHALL latch data and go to W_HAVE_DATA.
REQ-015 W_HAVE_ADDR on W handshake, or W_HAVE_DATA on AW handshake, SHALL commit the write and go to W_RESP.
REQ-016 W_RESP SHALL hold BVALID=1 with stable BRESP until BVALID&BREADY, then return to W_IDLE; BVALID rises the cycle after commit.
REQ-017 BRESP SHALL be 2'b00 (OKAY) for in-range writes and 2'b10 (SLVERR) for out-of-range writes; out-of-range writes leave memory unchanged.
REQ-018 SHALL implement read FSM states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE.
REQ-019 On AR handshake, SHALL register RDATA from memory and assert RVALID the next cycle; out-of-range reads return 32'h0000_0000.
REQ-020 R_DATA SHALL hold RVALID=1 and RDATA stable until RVALID&RREADY, then return to R_IDLE; at most one read is outstanding.
REQ-021 Read and write channels SHALL operate independently and concurrently.
REQ-022 A read handshake in the same cycle as a write commit to the same word SHALL return the pre-write value.
REQ-023 Valid/ready signals driven by this block SHALL not depend combinationally on any input valid (registered state only).

Reset
REQ-024 ARESET high SHALL immediately force AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, RVALID=0, BRESP=2'b00, RDATA=0, both FSMs to IDLE, and all memory words to RESET_VALUE.
REQ-025 Reset asserted mid-transaction SHALL discard latched address/data with no memory update; after release, ready outputs go high on the first clock edge.

Configuration
REQ-026 Macro AXI_LITE_SLAVE_PROT_CHECK_EN: when defined, an in-range access with PROT[0]=0 (unprivileged) SHALL complete normally in handshake timing but return SLVERR and no memory update for writes, and RDATA=0 for reads.
REQ-027 Without AXI_LITE_SLAVE_PROT_CHECK_EN, AWPROT and ARPROT SHALL be ignored and the check logic SHALL not be present.

Verification
REQ-028 Same-cycle AW 0x04 + W 0xA5A5_A5A5, BREADY=1 -> BVALID one cycle later, BRESP=00; read 0x04 -> RDATA=0xA5A5_A5A5.
REQ-029 W 0x1234_5678 three cycles before AW 0x08 -> WREADY low until AW; single BVALID OKAY; read 0x08 returns 0x1234_5678.
REQ-030 Write AWADDR 0x0000_0100 (DEPTH=16) -> BRESP=10; read 0x100 -> RDATA=0; all words unchanged.
REQ-031 Hold BREADY=0 10 cycles after a write -> BVALID stays 1, BRESP stable, AWREADY/WREADY stay 0; with RREADY=0 likewise RVALID/RDATA held.
REQ-032 Assert ARESET while in W_HAVE_ADDR for 0x0C -> all valids 0 asynchronously, word 3 = RESET_VALUE after release.
REQ-033 With AXI_LITE_SLAVE_PROT_CHECK_EN, write 0x00 AWPROT=3'b000 -> BRESP=10, word 0 unchanged; AWPROT=3'b001 -> BRESP=00.
